lvds_rx_deser: RTL and testbench

Single-clock behavioural 1:S serial-to-parallel receiver for D data lanes plus one forwarded-clock (frame) lane, used ahead of the ADC capture logic. It assembles MSB-first words and emits a one-cycle word strobe. It also supports manual bit-slip and optional automatic word alignment against two reference patterns on the clock lane. All lanes share one word-boundary counter, so every slip moves all lanes together.

---
 rtl/lvds_rx_deser.sv | 213 +++++++++++++++++++++
 tb/tb_lvds_rx_deser.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_deser.sv
// lvds_rx_deser: 1:S serial-to-parallel receiver for D data lanes plus one
// forwarded-clock lane. All lanes share one word-boundary counter, so a slip
// moves every lane by one bit. The clock-lane word can optionally be used to
// search for alignment automatically by slipping until it matches a pattern.
module lvds_rx_deser #(
  parameter int S         = 8,
  parameter int D         = 3,
  parameter int BS        = 0,
  parameter int SLIP_WAIT = 2
) (
  input  logic           gclk,
  input  logic           reset,
  input  logic           clkin,
  input  logic [D-1:0]   datain,
  input  logic [S-1:0]   pattern1,
  input  logic [S-1:0]   pattern2,
  input  logic           bitslip,
  output logic [D*S-1:0] data_out,
  output logic [S-1:0]   clk_word,
  output logic           rx_serdesstrobe,
  output logic           slip_pulse,
  output logic           aligned
);

  localparam int CW = $clog2(S);
  localparam int LW = $clog2(S + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(S - 1);
  localparam logic [LW-1:0] LOCK_LEN = LW'(S);
  localparam logic [WW-1:0] WAIT_LEN = WW'(SLIP_WAIT);
  localparam bit            AUTO_EN  = (BS != 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_ALIGNED = 2'd3
  } align_state_t;

  logic [S-1:0]  lane_sreg_r [D];
  logic [S-1:0]  clk_sreg_r;
  logic [S-1:0]  lane_word_s [D];
  logic [S-1:0]  clk_word_s;
  logic [CW-1:0] cnt_r;
  logic [LW-1:0] lock_r;
  logic [WW-1:0] wait_cnt_r;
  logic [WW-1:0] wait_cnt_s;
  align_state_t  state_r;
  align_state_t  state_s;
  logic          capture_s;
  logic          pattern_hit_s;
  logic          auto_req_s;
  logic          manual_req_s;
  logic          slip_acc_s;
  logic          aligned_s;

  // Word as it will look once the current sample is shifted in (MSB = earliest bit).
  always_comb begin
    for (int i = 0; i < D; i++) begin
      lane_word_s[i] = {lane_sreg_r[i][S-2:0], datain[i]};
    end
    clk_word_s = {clk_sreg_r[S-2:0], clkin};
  end

  // Capture at the last phase, except the repeated last phase produced by a slip held there.
  always_comb begin
    capture_s     = (cnt_r == CNT_LAST) && !slip_pulse;
    pattern_hit_s = (clk_word == pattern1) || (clk_word == pattern2);
    manual_req_s  = bitslip && (!AUTO_EN || aligned);
    slip_acc_s    = ((AUTO_EN && auto_req_s) || manual_req_s) && (lock_r == '0);
  end

  // Alignment search: next state, wait counter and automatic slip request.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    auto_req_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_serdesstrobe) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (rx_serdesstrobe) begin
          if (pattern_hit_s) begin
            state_s = ST_ALIGNED;
          end else begin
            auto_req_s = 1'b1;
            wait_cnt_s = WAIT_LEN;
            state_s    = ST_WAIT;
          end
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_WAIT: begin
        if (rx_serdesstrobe) begin
          if (wait_cnt_r <= WW'(1)) begin
            wait_cnt_s = '0;
            state_s    = ST_CHECK;
          end else begin
            wait_cnt_s = wait_cnt_r - WW'(1);
            state_s    = ST_WAIT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ALIGNED: begin
        state_s = ST_ALIGNED;
      end
      default: begin
        state_s    = ST_IDLE;
        wait_cnt_s = '0;
      end
    endcase
  end

  // Alignment flag: from the search FSM, or simply the first word when search is off.
  always_comb begin
    aligned_s = aligned;
    if (AUTO_EN) begin
      aligned_s = (state_s == ST_ALIGNED);
    end else if (capture_s) begin
      aligned_s = 1'b1;
    end else begin
      aligned_s = aligned;
    end
  end

  // Per-lane shift registers, shifted every cycle.
  always_ff @(posedge gclk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        lane_sreg_r[i] <= '0;
      end
      clk_sreg_r <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        lane_sreg_r[i] <= lane_word_s[i];
      end
      clk_sreg_r <= clk_word_s;
    end
  end

  // Shared word-phase counter; an accepted slip holds it for one cycle.
  always_ff @(posedge gclk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (slip_acc_s) begin
      cnt_r <= cnt_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Slip lockout: no new slip within S cycles of an accepted one; slip_pulse flags each slip.
  always_ff @(posedge gclk) begin
    if (reset) begin
      lock_r     <= '0;
      slip_pulse <= 1'b0;
    end else begin
      slip_pulse <= slip_acc_s;
      if (slip_acc_s) begin
        lock_r <= LOCK_LEN;
      end else if (lock_r != '0) begin
        lock_r <= lock_r - LW'(1);
      end else begin
        lock_r <= lock_r;
      end
    end
  end

  // Parallel word outputs and the word strobe.
  always_ff @(posedge gclk) begin
    if (reset) begin
      data_out        <= '0;
      clk_word        <= '0;
      rx_serdesstrobe <= 1'b0;
    end else begin
      rx_serdesstrobe <= capture_s;
      if (capture_s) begin
        for (int i = 0; i < D; i++) begin
          data_out[i*S +: S] <= lane_word_s[i];
        end
        clk_word <= clk_word_s;
      end else begin
        data_out <= data_out;
        clk_word <= clk_word;
      end
    end
  end

  // Alignment FSM state, wait counter and aligned flag.
  always_ff @(posedge gclk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
      aligned    <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      aligned    <= aligned_s;
    end
  end

endmodule

// File: tb/tb_lvds_rx_deser.sv
// Testbench for lvds_rx_deser: one instance with manual slip only (BS=0) and
// one with automatic alignment (BS=1), both checked every cycle against a
// sample-history reference model, plus directed table and corner sequences.
module tb_lvds_rx_deser;

  localparam int S  = 8;
  localparam int D  = 3;
  localparam int SW = 2;
  localparam int HN = 4096;

  logic           gclk;
  logic           rst_v     [2];
  logic           clkin_v   [2];
  logic [D-1:0]   datain_v  [2];
  logic [S-1:0]   p1_v      [2];
  logic [S-1:0]   p2_v      [2];
  logic           bitslip_v [2];
  logic [D*S-1:0] dout_v    [2];
  logic [S-1:0]   cword_v   [2];
  logic           stb_v     [2];
  logic           slp_v     [2];
  logic           aln_v     [2];

  lvds_rx_deser #(.S(S), .D(D), .BS(0), .SLIP_WAIT(SW)) u_man (
    .gclk(gclk), .reset(rst_v[0]), .clkin(clkin_v[0]), .datain(datain_v[0]),
    .pattern1(p1_v[0]), .pattern2(p2_v[0]), .bitslip(bitslip_v[0]),
    .data_out(dout_v[0]), .clk_word(cword_v[0]), .rx_serdesstrobe(stb_v[0]),
    .slip_pulse(slp_v[0]), .aligned(aln_v[0])
  );

  lvds_rx_deser #(.S(S), .D(D), .BS(1), .SLIP_WAIT(SW)) u_auto (
    .gclk(gclk), .reset(rst_v[1]), .clkin(clkin_v[1]), .datain(datain_v[1]),
    .pattern1(p1_v[1]), .pattern2(p2_v[1]), .bitslip(bitslip_v[1]),
    .data_out(dout_v[1]), .clk_word(cword_v[1]), .rx_serdesstrobe(stb_v[1]),
    .slip_pulse(slp_v[1]), .aligned(aln_v[1])
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // stimulus generators
  logic [S-1:0] cbyte [2];
  logic [S-1:0] dbyte [2][D];
  bit           drand [2];
  int           phase [2];

  // reference model
  int             m_t    [2];
  int             m_next [2];
  int             m_last [2];
  int             m_skip [2];
  bit [D:0]       hist   [2][HN];
  logic [D*S-1:0] e_dout [2];
  logic [S-1:0]   e_clk  [2];
  logic           e_stb  [2];
  logic           e_slp  [2];
  logic           e_aln  [2];

  // observers
  int obs_slip [2];
  int since_stb [2];
  bit have_stb [2];
  int ivl_min [2];
  int ivl_max [2];

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] byte_v;
    int         slips;
    logic [7:0] exp_word;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [S-1:0] rotl(input logic [S-1:0] b, input int k);
    logic [2*S-1:0] w;
    int kk;
    kk = k % S;
    w = {b, b};
    return w[2*S-1-kk -: S];
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t actual=%h required=%h", name, idx, $time, act, exp);
    end
  endtask

  task automatic gen_inputs(input int i);
    int ph;
    if (rst_v[i]) begin
      phase[i] = 0;
      clkin_v[i] = 1'b0;
      datain_v[i] = '0;
    end else begin
      ph = S - 1 - (phase[i] % S);
      clkin_v[i] = cbyte[i][ph];
      for (int l = 0; l < D; l++) begin
        datain_v[i][l] = drand[i] ? logic'($urandom_range(1, 0)) : dbyte[i][l][ph];
      end
      phase[i]++;
    end
  endtask

  // One cycle of the reference: words are the last S samples at each boundary,
  // boundaries fall every S cycles and an accepted slip pushes the next one out by one.
  task automatic model_step(input int i);
    bit bs;
    bit req;
    bit acc;
    bit aln_n;
    bit [D:0] smp;
    bs = (i == 1);
    if (rst_v[i]) begin
      m_t[i] = 0; m_next[i] = S - 1; m_last[i] = -1000; m_skip[i] = 1;
      e_dout[i] = '0; e_clk[i] = '0; e_stb[i] = 1'b0; e_slp[i] = 1'b0; e_aln[i] = 1'b0;
      return;
    end
    hist[i][m_t[i] % HN] = {clkin_v[i], datain_v[i]};
    req = 1'b0;
    aln_n = e_aln[i];
    if (bs && e_stb[i] && !e_aln[i]) begin
      if (m_skip[i] > 0) m_skip[i] = m_skip[i] - 1;
      else if (e_clk[i] == p1_v[i] || e_clk[i] == p2_v[i]) aln_n = 1'b1;
      else begin
        req = 1'b1;
        m_skip[i] = SW;
      end
    end
    if (bitslip_v[i] && (!bs || e_aln[i])) req = 1'b1;
    acc = req && (m_t[i] - m_last[i] > S);
    e_stb[i] = 1'b0;
    if (m_t[i] == m_next[i]) begin
      e_stb[i] = 1'b1;
      for (int k = 0; k < S; k++) begin
        smp = hist[i][(m_t[i] - S + 1 + k) % HN];
        e_clk[i][S-1-k] = smp[D];
        for (int l = 0; l < D; l++) e_dout[i][l*S + S-1-k] = smp[l];
      end
      m_next[i] = m_t[i] + S;
      if (!bs) aln_n = 1'b1;
    end
    if (acc) begin
      m_next[i] = m_next[i] + 1;
      m_last[i] = m_t[i];
    end
    e_slp[i] = acc;
    e_aln[i] = aln_n;
    m_t[i]++;
  endtask

  task automatic clear_obs(input int i);
    obs_slip[i] = 0; since_stb[i] = 0; have_stb[i] = 1'b0;
    ivl_min[i] = 1000; ivl_max[i] = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("data_out", i, 32'(dout_v[i]), 32'(e_dout[i]));
      chk("clk_word", i, 32'(cword_v[i]), 32'(e_clk[i]));
      chk("strobe", i, 32'(stb_v[i]), 32'(e_stb[i]));
      chk("slip_pulse", i, 32'(slp_v[i]), 32'(e_slp[i]));
      chk("aligned", i, 32'(aln_v[i]), 32'(e_aln[i]));
      if (slp_v[i] === 1'b1) obs_slip[i]++;
      since_stb[i]++;
      if (stb_v[i] === 1'b1) begin
        if (have_stb[i]) begin
          if (since_stb[i] < ivl_min[i]) ivl_min[i] = since_stb[i];
          if (since_stb[i] > ivl_max[i]) ivl_max[i] = since_stb[i];
        end
        have_stb[i] = 1'b1;
        since_stb[i] = 0;
      end
    end
  endtask

  task automatic step(input logic s0, input logic s1);
    bitslip_v[0] = s0;
    bitslip_v[1] = s1;
    for (int i = 0; i < 2; i++) begin
      gen_inputs(i);
      model_step(i);
    end
    @(posedge gclk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0);
  endtask

  task automatic reset_one(input int i);
    rst_v[i] = 1'b1;
    run(2);
    rst_v[i] = 1'b0;
    clear_obs(i);
  endtask

  initial begin
    tbl[0] = '{8'h05, 0, 8'h05};
    tbl[1] = '{8'h05, 1, 8'h0A};
    tbl[2] = '{8'h05, 3, 8'h28};
    tbl[3] = '{8'hF0, 2, 8'hC3};
    tbl[4] = '{8'h81, 4, 8'h18};
    tbl[5] = '{8'h05, 8, 8'h05};

    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; bitslip_v[i] = 1'b0; drand[i] = 1'b0; phase[i] = 0;
      cbyte[i] = 8'hF0; p1_v[i] = 8'h00; p2_v[i] = 8'hFF;
      dbyte[i][0] = 8'h05; dbyte[i][1] = 8'h3C; dbyte[i][2] = 8'hA5;
      clear_obs(i);
    end
    cbyte[1] = 8'hFF;
    run(2);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    clear_obs(0);
    clear_obs(1);

    // Table: manual slips rotate lane 0 left by the slip count.
    for (int v = 0; v < 6; v++) begin
      dbyte[0][0] = tbl[v].byte_v;
      reset_one(0);
      run(12);
      for (int k = 0; k < tbl[v].slips; k++) begin
        step(1'b1, 1'b0);
        run(10);
      end
      run(20);
      chk("tbl_word", v, 32'(dout_v[0][7:0]), 32'(tbl[v].exp_word));
      chk("tbl_slips", v, 32'(obs_slip[0]), 32'(tbl[v].slips));
      chk("tbl_aligned", v, 32'(aln_v[0]), 32'd1);
    end

    // Strobe spacing 8, single 9-cycle period around one slip.
    dbyte[0][0] = 8'h05;
    reset_one(0);
    run(40);
    chk("ivl_min_noslip", 0, 32'(ivl_min[0]), 32'd8);
    chk("ivl_max_noslip", 0, 32'(ivl_max[0]), 32'd8);
    step(1'b1, 1'b0);
    run(30);
    chk("ivl_max_slip", 0, 32'(ivl_max[0]), 32'd9);
    chk("ivl_min_slip", 0, 32'(ivl_min[0]), 32'd8);
    chk("one_slip_word", 0, 32'(dout_v[0][7:0]), 32'h0A);
    chk("one_slip_count", 0, 32'(obs_slip[0]), 32'd1);

    // Second request 3 cycles after an accepted slip is dropped.
    clear_obs(0);
    step(1'b1, 1'b0);
    run(2);
    step(1'b1, 1'b0);
    run(20);
    chk("lockout_slips", 0, 32'(obs_slip[0]), 32'd1);

    // Automatic alignment: clock lane 0xF0 searching for 0x0F.
    cbyte[1] = 8'hF0; p1_v[1] = 8'h0F; p2_v[1] = 8'h0F; dbyte[1][0] = 8'h12;
    reset_one(1);
    run(200);
    chk("auto_slips", 1, 32'(obs_slip[1]), 32'd4);
    chk("auto_aligned", 1, 32'(aln_v[1]), 32'd1);
    chk("auto_clk_word", 1, 32'(cword_v[1]), 32'h0F);
    chk("auto_lane0", 1, 32'(dout_v[1][7:0]), 32'h21);
    step(1'b0, 1'b1);
    run(30);
    chk("auto_manual_slips", 1, 32'(obs_slip[1]), 32'd5);
    chk("auto_manual_clk", 1, 32'(cword_v[1]), 32'h1E);

    // Already aligned clock lane; manual slip ignored while unaligned; mid-word reset.
    cbyte[1] = 8'hFF; p1_v[1] = 8'h00; p2_v[1] = 8'hFF;
    reset_one(1);
    step(1'b0, 1'b1);
    run(30);
    chk("pre_slips", 1, 32'(obs_slip[1]), 32'd0);
    chk("pre_aligned", 1, 32'(aln_v[1]), 32'd1);
    run(3);
    rst_v[1] = 1'b1;
    step(1'b0, 1'b0);
    rst_v[1] = 1'b0;
    chk("rst_aligned", 1, 32'(aln_v[1]), 32'd0);
    chk("rst_data", 1, 32'(dout_v[1]), 32'd0);
    chk("rst_clk", 1, 32'(cword_v[1]), 32'd0);
    run(40);
    chk("post_rst_aligned", 1, 32'(aln_v[1]), 32'd1);

    // Randomized streams, slips and resets against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++) begin
        cbyte[i] = 8'($urandom);
        p1_v[i] = ($urandom_range(1, 0) == 1) ? rotl(cbyte[i], $urandom_range(S-1, 0)) : 8'($urandom);
        p2_v[i] = 8'($urandom);
        drand[i] = 1'b1;
        rst_v[i] = 1'b1;
      end
      run(2);
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      for (int c = 0; c < 400; c++) begin
        rst_v[0] = ($urandom_range(249, 0) == 0);
        rst_v[1] = ($urandom_range(249, 0) == 0);
        step(logic'($urandom_range(6, 0) == 0), logic'($urandom_range(6, 0) == 0));
      end
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
